// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with fill level, thresholds,
// flush, and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   err_clr,
  input  logic                   wr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic rd_ok;
  logic wr_ok;

  // A read frees a slot in the same edge, so a full FIFO
  // still takes a write when a read is accepted alongside.
  assign rd_ok = rd & ~empty_q;
  assign wr_ok = wr & (~full_q | rd_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = (ovf_q & ~err_clr) | (wr & ~wr_ok);
    unf_d      = (unf_q & ~err_clr) | (rd & ~rd_ok);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at WIDTH=8, DEPTH=16,
// with hand-computed expected values per scenario.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       err_clr;
  logic       wr;
  logic [7:0] wr_data;
  logic       rd;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_rd;

  sync_fifo_param #(
    .WIDTH(8),
    .DEPTH(16),
    .AF_LEVEL(14),
    .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .err_clr(err_clr),
    .wr(wr),
    .wr_data(wr_data),
    .rd(rd),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({count, empty, full, almost_empty, almost_full}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_flags got c=%0d e=%b f=%b ae=%b af=%b want 0 1 0 1 0",
               count, empty, full, almost_empty, almost_full);
    end
    n_vec++;
    if ({rd_data, rd_valid, overflow, underflow} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_out got d=%h v=%b o=%b u=%b want 00 0 0 0",
               rd_data, rd_valid, overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1;
      wr_data = 8'(i);
      step();
      n_vec++;
      if (count !== 5'(i) || almost_full !== (i >= 14) ||
          full !== (i == 16) || almost_empty !== (i <= 2)) begin
        n_err++;
        $display("FAIL fill_%0d got c=%0d af=%b f=%b ae=%b", i, count,
                 almost_full, full, almost_empty);
      end
    end
    wr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      rd = 1'b1;
      step();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i) ||
          count !== 5'(16 - i)) begin
        n_err++;
        $display("FAIL drain_%0d got v=%b d=%h c=%0d want 1 %h %0d", i,
                 rd_valid, rd_data, count, 8'(i), 16 - i);
      end
    end
    rd = 1'b0;
    step();
    n_vec++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h10) begin
      n_err++;
      $display("FAIL drain_end got v=%b e=%b d=%h want 0 1 10",
               rd_valid, empty, rd_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1;
      wr_data = 8'(8'h20 + i);
      step();
    end
    wr_data = 8'hFF;
    step();
    wr = 1'b0;
    n_vec++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set got o=%b c=%0d f=%b want 1 16 1",
               overflow, count, full);
    end
    wr = 1'b1; rd = 1'b1; wr_data = 8'h50;
    step();
    n_vec++;
    if (rd_data !== 8'h21 || rd_valid !== 1'b1 || count !== 5'd16) begin
      n_err++;
      $display("FAIL full_rw got d=%h v=%b c=%0d want 21 1 16",
               rd_data, rd_valid, count);
    end
    wr = 1'b0; rd = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr got %b want 0", overflow);
    end
    wr = 1'b1; rd = 1'b1; wr_data = 8'h51;
    step();
    wr = 1'b0; rd = 1'b0;
    n_vec++;
    if (overflow !== 1'b0 || rd_data !== 8'h22 || count !== 5'd16) begin
      n_err++;
      $display("FAIL full_rw2 got o=%b d=%h c=%0d want 0 22 16",
               overflow, rd_data, count);
    end
    for (int i = 0; i < 16; i++) begin
      automatic logic [7:0] exp;
      exp = (i < 14) ? 8'(8'h23 + i) : 8'(8'h50 + i - 14);
      rd = 1'b1;
      step();
      n_vec++;
      if (rd_data !== exp || rd_valid !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_drain_%0d got d=%h v=%b want %h 1", i,
                 rd_data, rd_valid, exp);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    step();
    n_vec++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h51) begin
      n_err++;
      $display("FAIL unf_set got u=%b v=%b d=%h want 1 0 51",
               underflow, rd_valid, rd_data);
    end
    err_clr = 1'b1;
    step();
    n_vec++;
    if (underflow !== 1'b1) begin
      n_err++;
      $display("FAIL unf_set_wins got %b want 1", underflow);
    end
    rd = 1'b0;
    step();
    err_clr = 1'b0;
    n_vec++;
    if (underflow !== 1'b0) begin
      n_err++;
      $display("FAIL unf_clr got %b want 0", underflow);
    end
    wr = 1'b1; rd = 1'b1; wr_data = 8'h77;
    step();
    wr = 1'b0; rd = 1'b0;
    n_vec++;
    if (count !== 5'd1 || rd_valid !== 1'b0 || empty !== 1'b0 ||
        underflow !== 1'b1) begin
      n_err++;
      $display("FAIL empty_rw got c=%0d v=%b e=%b u=%b want 1 0 0 1",
               count, rd_valid, empty, underflow);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if (rd_data !== 8'h77 || rd_valid !== 1'b1 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL empty_rw_read got d=%h v=%b e=%b want 77 1 1",
               rd_data, rd_valid, empty);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1;
      wr_data = 8'(8'h60 + i);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      wr = 1'b1; rd = 1'b1;
      wr_data = 8'(8'h65 + k);
      step();
      n_vec++;
      if (count !== 5'd5 || rd_data !== 8'(8'h60 + k) ||
          rd_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stream_%0d got c=%0d d=%h v=%b want 5 %h 1", k,
                 count, rd_data, rd_valid, 8'(8'h60 + k));
      end
    end
    wr = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      n_vec++;
      if (rd_data !== 8'(8'h88 + j)) begin
        n_err++;
        $display("FAIL stream_drain_%0d got %h want %h", j, rd_data,
                 8'(8'h88 + j));
      end
    end
    rd = 1'b0;
    last_rd = 8'h8C;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) begin
      wr = 1'b1;
      wr_data = 8'(8'h90 + i);
      step();
    end
    n_vec++;
    if (count !== 5'd9) begin
      n_err++;
      $display("FAIL pre_flush got c=%0d want 9", count);
    end
    flush = 1'b1; wr_data = 8'hEE;
    step();
    flush = 1'b0; wr = 1'b0;
    n_vec++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
        rd_valid !== 1'b0 || rd_data !== last_rd ||
        almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL flush got c=%0d e=%b f=%b v=%b d=%h ae=%b want 0 1 0 0 %h 1",
               count, empty, full, rd_valid, rd_data, almost_empty, last_rd);
    end
    wr = 1'b1; wr_data = 8'hAA;
    step();
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if (rd_data !== 8'hAA || rd_valid !== 1'b1 || count !== 5'd0) begin
      n_err++;
      $display("FAIL post_flush got d=%h v=%b c=%0d want AA 1 0",
               rd_data, rd_valid, count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      wr_data = 8'(8'hB0 + i);
      step();
    end
    wr = 1'b0; rd = 1'b1;
    step();
    rd = 1'b0;
    n_vec++;
    if (count !== 5'd7 || rd_valid !== 1'b1 || rd_data !== 8'hB0) begin
      n_err++;
      $display("FAIL pre_reset got c=%0d v=%b d=%h want 7 1 B0",
               count, rd_valid, rd_data);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({count, empty, full, almost_empty, almost_full, rd_valid}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0} || rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset got c=%0d e=%b f=%b ae=%b af=%b v=%b d=%h",
               count, empty, full, almost_empty, almost_full, rd_valid,
               rd_data);
    end
    #4;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; err_clr = 1'b0;
    wr = 1'b0; rd = 1'b0; wr_data = 8'h00;
    last_rd = 8'h00;
    #2;
    reset = 1'b0;
    #10;
    test_reset();
    reset = 1'b1;
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
